// File: rtl/dm_responder.sv
// Single-port word-addressed data memory responder with a request/response handshake.
// Each accepted request is answered exactly once, WAIT_CYCLES+1 cycles after acceptance.
module dm_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int          IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] LIMIT     = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state;
    logic [3:0]    counter;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    byteen_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic [31:0]   src_addr;
    logic [31:0]   src_wdata;
    logic [3:0]    src_byteen;
    logic          in_range;
    logic [IW-1:0] idx;
    logic [31:0]   old_word;
    logic [31:0]   merged;

    assign req_ready = (state == S_IDLE) && !reset;
    assign busy      = (state != S_IDLE);

    // With WAIT_CYCLES=0 the response is produced on the acceptance edge itself,
    // before the request registers are loaded, so the live inputs are used then.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        accept     = req_valid && req_ready;
        src_addr   = (state == S_IDLE) ? req_addr   : addr_q;
        src_wdata  = (state == S_IDLE) ? req_wdata  : wdata_q;
        src_byteen = (state == S_IDLE) ? req_byteen : byteen_q;
        in_range   = (src_addr < LIMIT);
        idx        = src_addr[IW+1:2];
        old_word   = in_range ? mem[idx] : 32'd0;
        merged     = old_word;
        for (int i = 0; i < 4; i++) begin
            if (src_byteen[i]) merged[8*i +: 8] = src_wdata[8*i +: 8];
        end
        enter_resp = ((state == S_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                     ((state == S_WAIT) && (counter == 4'd0));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            counter   <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            byteen_q  <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= in_range ? merged : 32'd0;
                rsp_err   <= !in_range;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        byteen_q <= req_byteen;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state   <= S_WAIT;
                            counter <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (counter == 4'd0) state <= S_RESP;
                    else                 counter <= counter - 4'd1;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the array itself is cleared by reset, which forces it into flops rather
    // than a RAM macro; a write still pending when reset hits is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
        end else if (enter_resp && in_range && (src_byteen != 4'd0)) begin
            mem[idx] <= merged;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: one instance with WAIT_CYCLES=2 and one with
// WAIT_CYCLES=0, both compared against an associative-array memory model.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid2, valid0;
    logic [31:0] addr, wdata;
    logic [3:0]  byteen;

    logic        ready2, rsp_valid2, err2, busy2;
    logic [31:0] rdata2;
    logic        ready0, rsp_valid0, err0, busy0;
    logic [31:0] rdata0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model2 [int];
    logic [31:0] model0 [int];

    always #5 clk = ~clk;

    dm_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(3072)) dut2 (
        .clk(clk), .reset(reset), .req_valid(valid2), .req_ready(ready2),
        .req_addr(addr), .req_byteen(byteen), .req_wdata(wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rdata2), .rsp_err(err2), .busy(busy2));

    dm_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(3072)) dut0 (
        .clk(clk), .reset(reset), .req_valid(valid0), .req_ready(ready0),
        .req_addr(addr), .req_byteen(byteen), .req_wdata(wdata),
        .rsp_valid(rsp_valid0), .rsp_rdata(rdata0), .rsp_err(err0), .busy(busy0));

    // Reference: a word store keyed by byte address / 4; anything above 0x2fff is an error.
    task automatic model_apply(input bit w0, input logic [31:0] a, input logic [3:0] be,
                               input logic [31:0] wd, output logic [31:0] rd, output logic e);
        logic [31:0] word;
        int key;
        if (a > 32'h2fff) begin
            rd = 32'd0;
            e  = 1'b1;
            return;
        end
        key = int'(a >> 2);
        if (w0) word = model0.exists(key) ? model0[key] : 32'd0;
        else    word = model2.exists(key) ? model2[key] : 32'd0;
        for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
        if (be != 4'd0) begin
            if (w0) model0[key] = word;
            else    model2[key] = word;
        end
        rd = word;
        e  = 1'b0;
    endtask

    // Called at a negedge. Issues one request, scrambles the inputs after acceptance,
    // measures cycles to rsp_valid (1 = cycle right after the acceptance edge),
    // then checks the response fields hold for the following cycle.
    task automatic txn(input bit w0, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e,
                       output int lat);
        int guard;
        guard = 0;
        while ((w0 ? ready0 : ready2) !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (guard >= 40) begin
            n_fail++;
            $display("FAIL txn_ready_timeout: req_ready stayed low for %0d cycles, required 1", guard);
        end
        addr = a; byteen = be; wdata = wd;
        if (w0) valid0 = 1'b1; else valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid0 = 1'b0; valid2 = 1'b0;
        addr = $urandom; byteen = 4'($urandom); wdata = $urandom;
        lat = 1;
        while ((w0 ? rsp_valid0 : rsp_valid2) !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = w0 ? rdata0 : rdata2;
        e  = w0 ? err0 : err2;
        @(negedge clk);
        n_tests++;
        if ((w0 ? rsp_valid0 : rsp_valid2) !== 1'b0 || (w0 ? rdata0 : rdata2) !== rd ||
            (w0 ? err0 : err2) !== e) begin
            n_fail++;
            $display("FAIL rsp_hold: valid=%b rdata=%h err=%b, required valid=0 rdata=%h err=%b",
                     w0 ? rsp_valid0 : rsp_valid2, w0 ? rdata0 : rdata2, w0 ? err0 : err2, rd, e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; valid2 = 1'b0; valid0 = 1'b0;
        addr = 32'd0; byteen = 4'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({ready2, rsp_valid2, err2, busy2} !== 4'b0000 || rdata2 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_w2: ready=%b valid=%b err=%b busy=%b rdata=%h, required all 0",
                     ready2, rsp_valid2, err2, busy2, rdata2);
        end
        n_tests++;
        if ({ready0, rsp_valid0, err0, busy0} !== 4'b0000 || rdata0 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_w0: ready=%b valid=%b err=%b busy=%b rdata=%h, required all 0",
                     ready0, rsp_valid0, err0, busy0, rdata0);
        end
        reset = 1'b0;
        model2.delete();
        model0.delete();
        @(posedge clk);
        #1;
        n_tests++;
        if (ready2 !== 1'b1 || ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: ready2=%b ready0=%b, required 1 1", ready2, ready0);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        e;
    } vec_t;

    task automatic test_directed();
        vec_t v [12];
        logic [31:0] rd, mrd;
        logic e, me;
        int lat;
        v[0]  = '{32'h0004, 4'b1111, 32'h12345678, 32'h12345678, 1'b0};
        v[1]  = '{32'h0004, 4'b0000, 32'h0,        32'h12345678, 1'b0};
        v[2]  = '{32'h0006, 4'b1100, 32'hABCD0000, 32'hABCD5678, 1'b0};
        v[3]  = '{32'h0004, 4'b0000, 32'h0,        32'hABCD5678, 1'b0};
        v[4]  = '{32'h0004, 4'b0010, 32'h0000EF00, 32'hABCDEF78, 1'b0};
        v[5]  = '{32'h0004, 4'b0000, 32'h0,        32'hABCDEF78, 1'b0};
        v[6]  = '{32'h3000, 4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b1};
        v[7]  = '{32'h2ffc, 4'b0000, 32'h0,        32'h00000000, 1'b0};
        v[8]  = '{32'h7f00, 4'b0000, 32'h0,        32'h00000000, 1'b1};
        v[9]  = '{32'h2fff, 4'b1001, 32'hAA0000BB, 32'hAA0000BB, 1'b0};
        v[10] = '{32'h2ffc, 4'b0011, 32'h00003344, 32'hAA003344, 1'b0};
        v[11] = '{32'h0004, 4'b0000, 32'h0,        32'hABCDEF78, 1'b0};
        for (int i = 0; i < 12; i++) begin
            model_apply(1'b0, v[i].a, v[i].be, v[i].wd, mrd, me);
            txn(1'b0, v[i].a, v[i].be, v[i].wd, rd, e, lat);
            n_tests++;
            if (rd !== v[i].rd || e !== v[i].e || lat != 3) begin
                n_fail++;
                $display("FAIL directed[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=3",
                         i, rd, e, lat, v[i].rd, v[i].e);
            end
        end
    endtask

    // req_valid held high: the responder must accept exactly every WAIT_CYCLES+2 cycles.
    task automatic test_back_to_back(input bit w0, input int period, input int cycles,
                                     input int want_accepts);
        int accepts;
        int guard;
        bit exp_ready;
        logic [31:0] rd;
        logic e;
        accepts = 0;
        addr = 32'h0100; byteen = 4'b0000; wdata = 32'd0;
        if (w0) valid0 = 1'b1; else valid2 = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            exp_ready = (k % period == 0);
            n_tests++;
            if ((w0 ? ready0 : ready2) !== exp_ready || (w0 ? busy0 : busy2) !== !exp_ready ||
                (w0 ? rsp_valid0 : rsp_valid2) !== (k % period == period - 1)) begin
                n_fail++;
                $display("FAIL b2b_w%0d[%0d]: ready=%b busy=%b valid=%b, required ready=%b busy=%b valid=%b",
                         w0 ? 0 : 2, k, w0 ? ready0 : ready2, w0 ? busy0 : busy2,
                         w0 ? rsp_valid0 : rsp_valid2, exp_ready, !exp_ready,
                         (k % period == period - 1));
            end
            if ((w0 ? ready0 : ready2) === 1'b1) accepts++;
            @(negedge clk);
        end
        valid0 = 1'b0; valid2 = 1'b0;
        n_tests++;
        if (accepts != want_accepts) begin
            n_fail++;
            $display("FAIL b2b_accepts_w%0d: got %0d acceptances, required %0d",
                     w0 ? 0 : 2, accepts, want_accepts);
        end
        guard = 0;
        while ((w0 ? busy0 : busy2) !== 1'b0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        model_apply(w0, 32'h0100, 4'b0000, 32'd0, rd, e);
        @(negedge clk);
    endtask

    task automatic test_random(input int count);
        logic [31:0] a, wd, rd, mrd;
        logic [3:0] be;
        logic e, me;
        bit w0;
        int lat, r;
        for (int i = 0; i < count; i++) begin
            w0 = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            if (r < 4)      a = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            else if (r < 7) a = 32'h2fe0 + 32'($urandom_range(0, 31));
            else if (r < 9) a = 32'h3000 + 32'($urandom_range(0, 16'hffff));
            else            a = $urandom | 32'h8000_0000;
            be = 4'($urandom_range(0, 15));
            wd = $urandom;
            model_apply(w0, a, be, wd, mrd, me);
            txn(w0, a, be, wd, rd, e, lat);
            n_tests++;
            if (rd !== mrd || e !== me || lat != (w0 ? 1 : 3)) begin
                n_fail++;
                $display("FAIL random[%0d] w%0d addr=%h be=%b: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                         i, w0 ? 0 : 2, a, be, rd, e, lat, mrd, me, w0 ? 1 : 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic e;
        int lat;
        txn(1'b0, 32'h0020, 4'b1111, 32'hCAFEF00D, rd, e, lat);
        n_tests++;
        if (rd !== 32'hCAFEF00D || e !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pre: rdata=%h err=%b, required cafef00d 0", rd, e);
        end
        addr = 32'h0010; byteen = 4'b1111; wdata = 32'hFFFFFFFF;
        valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid2 = 1'b0;
        reset  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid2 !== 1'b0 || ready2 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet[%0d]: valid=%b ready=%b, required 0 0", k, rsp_valid2, ready2);
            end
        end
        reset = 1'b0;
        model2.delete();
        model0.delete();
        @(negedge clk);
        n_tests++;
        if (rsp_valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_rsp: valid=%b, required 0", rsp_valid2);
        end
        txn(1'b0, 32'h0010, 4'b0000, 32'd0, rd, e, lat);
        n_tests++;
        if (rd !== 32'd0 || e !== 1'b0 || lat != 3) begin
            n_fail++;
            $display("FAIL reset_mid_uncommitted: rdata=%h err=%b lat=%0d, required 0 0 3", rd, e, lat);
        end
        txn(1'b0, 32'h0020, 4'b0000, 32'd0, rd, e, lat);
        n_tests++;
        if (rd !== 32'd0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_clears_array: rdata=%h err=%b, required 0 0", rd, e);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back(1'b0, 4, 10, 3);
        test_back_to_back(1'b1, 2, 6, 3);
        test_random(60);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 2, range 0..15: extra cycles between request acceptance and response.
REQ-002 SHALL provide parameter DEPTH_WORDS, default 3072: array size in 32-bit words, covering byte addresses 0x0000..0x2fff.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_addr  input  32  byte address; bits [1:0] are ignored for array indexing.
REQ-009 req_byteen  input  4  lane write enables; 4'b0000 means read.
REQ-010 req_wdata  input  32  lane-placed write data; lane i is bits [8i+7:8i].
REQ-011 rsp_valid  output  1  one-cycle response strobe.
REQ-012 rsp_rdata  output  32  response word.
REQ-013 rsp_err  output  1  response is an error; qualified by rsp_valid.
REQ-014 busy  output  1  a request has been accepted and its response is not yet delivered.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE with reset low; busy SHALL be 1 in WAIT and RESP.
REQ-017 A request SHALL be accepted on the edge where req_valid && req_ready.
- On acceptance, req_addr, req_byteen and req_wdata SHALL be latched.
- Input changes after acceptance SHALL be ignored.
REQ-018 On acceptance, the FSM SHALL go IDLE->WAIT and load the counter with WAIT_CYCLES-1; when WAIT_CYCLES=0 it SHALL go IDLE->RESP directly.
REQ-019 In WAIT the counter SHALL decrement each cycle; at counter 0 the FSM SHALL go WAIT->RESP.
REQ-020 RESP SHALL last exactly one cycle with rsp_valid=1, then go to IDLE.
- A new request can be accepted at the earliest in the cycle after RESP.
- Back-to-back period: WAIT_CYCLES+2 cycles.
REQ-021 Latency: a request accepted at edge T SHALL produce rsp_valid high in cycle T+1+WAIT_CYCLES.
REQ-022 Range check: the latched address SHALL be in range iff addr <= 0x2fff; the word index is addr[13:2].
REQ-023 An in-range write (byteen != 0) SHALL update only the enabled byte lanes, on the edge entering RESP.
- Disabled lanes SHALL keep their prior contents.
- rsp_rdata SHALL return the merged word after the write.
REQ-024 An in-range read SHALL sample the array on the edge entering RESP.
- rsp_rdata SHALL be the full word; lane selection and sign extension belong to the initiator.
REQ-025 An out-of-range request SHALL NOT modify the array, and its response SHALL be rsp_rdata=0, rsp_err=1.
REQ-026 Ordering: a read accepted after a write's RESP SHALL observe that write.
REQ-027 rsp_rdata and rsp_err SHALL hold their last values until the next response.
REQ-028 Only rsp_valid is pulsed; req_valid held high SHALL NOT be re-accepted while busy.
REQ-029 Byte-lane merge width rules: all lanes are 8 bits; byteen patterns of 0001, 0011, 1100, 1111 or any other value SHALL be honoured per bit.

Reset
REQ-030 While reset=1, the outputs SHALL be state=IDLE, counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
REQ-031 Reset SHALL clear all array words to 0.
REQ-032 Reset mid-operation (in WAIT or RESP) SHALL discard the pending request.
- No response SHALL be issued for it.
- A write not yet committed SHALL NOT be committed.
REQ-033 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-034 WAIT_CYCLES=2: write addr 0x0004, byteen 1111, wdata 0x12345678 at T -> rsp_valid in T+3, rsp_err=0, rsp_rdata=0x12345678; a later read of 0x0004 -> 0x12345678.
REQ-035 Lane merge: after the above, write addr 0x0006, byteen 1100, wdata 0xABCD0000 -> read 0x0004 returns 0xABCD5678; then byteen 0010, wdata 0x0000EF00 -> read returns 0xABCDEF78.
REQ-036 Out of range: write 0x3000, byteen 1111 -> rsp_err=1, rsp_rdata=0; read 0x2ffc -> 0x00000000 and rsp_err=0; read 0x7f00 -> rsp_err=1.
REQ-037 Handshake: req_valid held high for 10 cycles with WAIT_CYCLES=2 -> exactly 3 acceptances (period 4); req_ready=0 and busy=1 in each WAIT and RESP cycle.
REQ-038 WAIT_CYCLES=0: request at T -> rsp_valid in T+1; back-to-back requests accepted every 2 cycles.
REQ-039 Reset mid-operation: accept a write 0x0010 = 0xFFFFFFFF, assert reset in the first WAIT cycle -> no rsp_valid; a read of 0x0010 after reset -> 0x00000000.
